// File: rtl/challenge_arg_sched.sv
// Two-requester round-robin issue scheduler for a shared fixed-latency datapath.
// Optional sticky protocol checker on err is enabled by CHALLENGE_SCHED_ERRCHK_EN.
module challenge_arg_sched #(
    parameter int unsigned W        = 64,
    parameter int unsigned LAT      = 5,
    parameter int unsigned MAX_INFL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_vld,
    input  logic [W-1:0] req0_data,
    output logic         req0_rdy,
    input  logic         req1_vld,
    input  logic [W-1:0] req1_data,
    output logic         req1_rdy,
    input  logic         flush,
    output logic         arg_vld,
    output logic [W-1:0] in_data,
    input  logic         res_vld,
    input  logic [W-1:0] res_data,
    output logic         rsp_vld,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         busy,
    output logic         err
);
    localparam int unsigned   CW      = $clog2(MAX_INFL + 1);
    localparam logic [CW-1:0] MaxInfl = CW'(MAX_INFL);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  infl_q, infl_d;
    logic           ptr_q;
    logic           arg_vld_q, arg_id_q;
    logic [W-1:0]   in_data_q;
    logic [LAT-1:0] tag_vld_q, tag_id_q;
    logic           rsp_vld_q, rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic           can_grant, gnt0, gnt1, accept, win_id;
    logic           tag_out_vld, tag_out_id;

    assign tag_out_vld = tag_vld_q[LAT-1];
    assign tag_out_id  = tag_id_q[LAT-1];

    // A returning result frees its slot in the same cycle, so it may be regranted at once.
    always_comb begin
        gnt0      = req0_vld && (!req1_vld || ptr_q);
        gnt1      = req1_vld && (!req0_vld || !ptr_q);
        can_grant = (state_q == StIssue) && !flush && ((infl_q < MaxInfl) || res_vld);
        req0_rdy  = can_grant && gnt0;
        req1_rdy  = can_grant && gnt1;
        accept    = req0_rdy || req1_rdy;
        win_id    = req1_rdy;
    end

    always_comb begin
        infl_d = infl_q;
        if (accept && !res_vld) begin
            infl_d = infl_q + 1'b1;
        end else if (!accept && res_vld && (infl_q != '0)) begin
            infl_d = infl_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if ((req0_vld || req1_vld) && !flush) state_d = StIssue;
            end
            StIssue: begin
                if (flush) begin
                    state_d = StDrain;
                end else if (!req0_vld && !req1_vld && (infl_q == '0)) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if ((infl_q == '0) && !flush) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            infl_q     <= '0;
            ptr_q      <= 1'b1;
            arg_vld_q  <= 1'b0;
            arg_id_q   <= 1'b0;
            in_data_q  <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q   <= state_d;
            infl_q    <= infl_d;
            arg_vld_q <= accept;
            if (accept) begin
                ptr_q     <= win_id;
                arg_id_q  <= win_id;
                in_data_q <= win_id ? req1_data : req0_data;
            end
            // Stage 0 follows arg_vld, so the last stage lines up with res_vld.
            tag_vld_q[0] <= arg_vld_q;
            tag_id_q[0]  <= arg_id_q;
            for (int i = 1; i < int'(LAT); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            // Results without a live tag (e.g. issued before a reset) are dropped.
            rsp_vld_q <= res_vld && tag_out_vld;
            if (res_vld) begin
                rsp_id_q   <= tag_out_id;
                rsp_data_q <= res_data;
            end
        end
    end

`ifdef CHALLENGE_SCHED_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((res_vld && !tag_out_vld) || (tag_out_vld && !res_vld) ||
                     (res_vld && !accept && (infl_q == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy     = (state_q != StIdle) || (infl_q != '0);
    assign arg_vld  = arg_vld_q;
    assign in_data  = in_data_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_challenge_arg_sched.sv
// Randomized self-checking bench for challenge_arg_sched with a transaction-level model
// of requesters, a fixed-latency datapath and expected issue/response streams.
module tb_challenge_arg_sched;
    localparam int unsigned W        = 64;
    localparam int unsigned LAT      = 5;
    localparam int unsigned MAX_INFL = 4;

    typedef struct {
        int           cyc;
        logic         id;
        logic [W-1:0] data;
    } ent_t;

    typedef struct {
        int           due;
        logic         id;
        logic [W-1:0] data;
        bit           orphan;
    } dp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_vld = 1'b0, req1_vld = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_rdy, req1_rdy;
    logic         flush = 1'b0;
    logic         arg_vld;
    logic [W-1:0] in_data;
    logic         res_vld = 1'b0;
    logic [W-1:0] res_data = '0;
    logic         rsp_vld, rsp_id;
    logic [W-1:0] rsp_data;
    logic         busy, err;

    challenge_arg_sched #(.W(W), .LAT(LAT), .MAX_INFL(MAX_INFL)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0_vld (req0_vld),
        .req0_data(req0_data),
        .req0_rdy (req0_rdy),
        .req1_vld (req1_vld),
        .req1_data(req1_data),
        .req1_rdy (req1_rdy),
        .flush    (flush),
        .arg_vld  (arg_vld),
        .in_data  (in_data),
        .res_vld  (res_vld),
        .res_data (res_data),
        .rsp_vld  (rsp_vld),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, m_infl = 0, acc_cnt = 0;
    int last_acc_cyc = 0, last_rsp_cyc = 0;
    logic m_last = 1'b1;
    bit rst_req = 1'b0, flush_req = 1'b0, hold_res = 1'b0, inj_res = 1'b0, free_chk = 1'b0;
    logic [W-1:0] q0[$], q1[$];
    ent_t iss_q[$], rsp_q[$];
    dp_t dp_q[$];
    logic acc_ids[$], rsp_ids[$];

    function automatic logic [W-1:0] dp_fn(input logic [W-1:0] x);
        return x ^ 64'hA5A5_0000_FFFF_5A5A;
    endfunction

    // One clock: drive at posedge+1, sample at negedge, update the model.
    task automatic cycle();
        bit drv, exp_a, exp_r, acc;
        logic acc_id;
        logic [W-1:0] dat;
        dp_t d;
        ent_t e;
        @(posedge clk);
        cyc++;
        #1;
        rst = rst_req;
        flush = flush_req;
        req0_vld = (q0.size() > 0);
        req0_data = req0_vld ? q0[0] : '0;
        req1_vld = (q1.size() > 0);
        req1_data = req1_vld ? q1[0] : '0;
        drv = 1'b0;
        res_vld = 1'b0;
        res_data = {$urandom, $urandom};
        if (inj_res) begin
            res_vld = 1'b1;
        end else if (!hold_res && dp_q.size() > 0 && dp_q[0].due <= cyc) begin
            d = dp_q.pop_front();
            res_vld = 1'b1;
            res_data = dp_fn(d.data);
            drv = !d.orphan;
        end
        @(negedge clk);
        if (rst) begin
            iss_q.delete();
            rsp_q.delete();
            foreach (dp_q[i]) dp_q[i].orphan = 1'b1;
            m_infl = 0;
            m_last = 1'b1;
            return;
        end
        exp_a = iss_q.size() > 0 && iss_q[0].cyc == cyc;
        if (exp_a) e = iss_q.pop_front();
        checks++;
        if (arg_vld !== exp_a) begin
            errors++;
            $display("FAIL arg_vld cyc=%0d got=%b want=%b", cyc, arg_vld, exp_a);
        end else if (exp_a) begin
            checks++;
            if (in_data !== e.data) begin
                errors++;
                $display("FAIL in_data cyc=%0d got=%h want=%h", cyc, in_data, e.data);
            end
            dp_q.push_back('{cyc + int'(LAT), e.id, e.data, 1'b0});
        end
        exp_r = rsp_q.size() > 0 && rsp_q[0].cyc == cyc;
        if (exp_r) e = rsp_q.pop_front();
        checks++;
        if (rsp_vld !== exp_r) begin
            errors++;
            $display("FAIL rsp_vld cyc=%0d got=%b want=%b", cyc, rsp_vld, exp_r);
        end else if (exp_r) begin
            checks++;
            if (rsp_id !== e.id || rsp_data !== e.data) begin
                errors++;
                $display("FAIL rsp cyc=%0d got id=%b data=%h want id=%b data=%h",
                         cyc, rsp_id, rsp_data, e.id, e.data);
            end
            rsp_ids.push_back(rsp_id);
            last_rsp_cyc = cyc;
        end
        if (drv) rsp_q.push_back('{cyc + 1, d.id, dp_fn(d.data)});
        checks++;
        if ((req0_rdy && req1_rdy) || (flush && (req0_rdy || req1_rdy))) begin
            errors++;
            $display("FAIL rdy_legal cyc=%0d got rdy0=%b rdy1=%b flush=%b want no grant",
                     cyc, req0_rdy, req1_rdy, flush);
        end
        acc = (req0_vld && req0_rdy) || (req1_vld && req1_rdy);
        acc_id = req1_vld && req1_rdy;
        if (acc) begin
            if (req0_vld && req1_vld) begin
                checks++;
                if (acc_id !== ~m_last) begin
                    errors++;
                    $display("FAIL arbitration cyc=%0d got=%b want=%b", cyc, acc_id, ~m_last);
                end
            end
            dat = acc_id ? q1.pop_front() : q0.pop_front();
            iss_q.push_back('{cyc + 1, acc_id, dat});
            m_last = acc_id;
            acc_ids.push_back(acc_id);
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (free_chk && m_infl == int'(MAX_INFL) && drv && (req0_vld || req1_vld) && !flush) begin
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL same_cycle_free cyc=%0d got accept=0 want accept=1", cyc);
            end
        end
        m_infl = m_infl + int'(acc) - int'(drv);
        checks++;
        if (m_infl > int'(MAX_INFL)) begin
            errors++;
            $display("FAIL infl_bound cyc=%0d got=%0d want<=%0d", cyc, m_infl, MAX_INFL);
        end
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        dp_q.delete();
        acc_cnt = 0;
        acc_ids.delete();
        rsp_ids.delete();
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back({$urandom, $urandom});
        n = 0;
        while (acc_cnt < 3 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (acc_cnt != 3) begin
            errors++;
            $display("FAIL reset_fill got=%0d want=3", acc_cnt);
        end
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        checks++;
        if (arg_vld !== 1'b0 || in_data !== '0 || rsp_vld !== 1'b0 || rsp_id !== 1'b0 ||
            rsp_data !== '0 || busy !== 1'b0 || err !== 1'b0 ||
            req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got arg=%b in=%h rsp=%b id=%b data=%h busy=%b err=%b want all 0",
                     arg_vld, in_data, rsp_vld, rsp_id, rsp_data, busy, err);
        end
        for (int i = 0; i < 12; i++) cycle();
        checks++;
        if (rsp_ids.size() != 0) begin
            errors++;
            $display("FAIL reset_discard got rsp count=%0d want=0", rsp_ids.size());
        end
`ifdef CHALLENGE_SCHED_ERRCHK_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL reset_orphan_err got=%b want=1", err);
        end
`endif
    endtask

    task automatic test_single();
        int n;
        do_reset();
        q0.push_back(64'h1234);
        n = 0;
        while (rsp_ids.size() < 1 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (rsp_ids.size() != 1) begin
            errors++;
            $display("FAIL single_rsp got count=%0d want=1", rsp_ids.size());
        end else begin
            checks++;
            if (last_rsp_cyc - last_acc_cyc != int'(LAT) + 2 || rsp_ids[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_latency got lat=%0d id=%b want lat=%0d id=0",
                         last_rsp_cyc - last_acc_cyc, rsp_ids[0], LAT + 2);
            end
        end
    endtask

    task automatic test_arb();
        int n;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            q0.push_back({$urandom, $urandom});
            q1.push_back({$urandom, $urandom});
        end
        n = 0;
        while (rsp_ids.size() < 4 && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (acc_ids.size() != 4 || rsp_ids.size() != 4) begin
            errors++;
            $display("FAIL arb_count got acc=%0d rsp=%0d want 4/4", acc_ids.size(), rsp_ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_ids[i] !== 1'(i % 2) || rsp_ids[i] !== 1'(i % 2)) begin
                    errors++;
                    $display("FAIL arb_order idx=%0d got acc=%b rsp=%b want=%0d",
                             i, acc_ids[i], rsp_ids[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        hold_res = 1'b1;
        free_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back({$urandom, $urandom});
            q1.push_back({$urandom, $urandom});
        end
        for (int i = 0; i < 14; i++) cycle();
        checks++;
        if (acc_cnt != int'(MAX_INFL) || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall got acc=%0d rdy0=%b rdy1=%b want acc=%0d rdy=0",
                     acc_cnt, req0_rdy, req1_rdy, MAX_INFL);
        end
        hold_res = 1'b0;
        cycle();
        checks++;
        if (acc_cnt != int'(MAX_INFL) + 1) begin
            errors++;
            $display("FAIL stall_release got acc=%0d want=%0d", acc_cnt, MAX_INFL + 1);
        end
        free_chk = 1'b0;
        do_reset();
    endtask

    task automatic test_flush();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back({$urandom, $urandom});
            q1.push_back({$urandom, $urandom});
        end
        n = 0;
        while (acc_cnt < 2 && n < 20) begin
            cycle();
            n++;
        end
        flush_req = 1'b1;
        n = 0;
        while (rsp_ids.size() < 2 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (rsp_ids.size() != 2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain got rsp=%0d busy=%b want rsp=2 busy=1", rsp_ids.size(), busy);
        end
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (acc_cnt != 2) begin
            errors++;
            $display("FAIL flush_stop got acc=%0d want=2", acc_cnt);
        end
        q0.delete();
        q1.delete();
        flush_req = 1'b0;
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy=%b want=0", busy);
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        free_chk = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0 && q0.size() < 3) q0.push_back({$urandom, $urandom});
            if ($urandom_range(0, 2) != 0 && q1.size() < 3) q1.push_back({$urandom, $urandom});
            cycle();
        end
        n = 0;
        while ((q0.size() + q1.size() + iss_q.size() + dp_q.size() + rsp_q.size()) != 0 && n < 200) begin
            cycle();
            n++;
        end
        cycle();
        free_chk = 1'b0;
        checks++;
        if (rsp_ids.size() != acc_cnt || acc_cnt < 100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got acc=%0d rsp=%0d busy=%b want equal counts, idle",
                     acc_cnt, rsp_ids.size(), busy);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL random_err got=%b want=0", err);
        end
    endtask

`ifdef CHALLENGE_SCHED_ERRCHK_EN
    task automatic test_errchk();
        do_reset();
        inj_res = 1'b1;
        cycle();
        inj_res = 1'b0;
        cycle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got=%b want=1", err);
        end
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
        do_reset();
        cycle();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b want=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_arb();
        test_stall();
        test_flush();
`ifdef CHALLENGE_SCHED_ERRCHK_EN
        test_errchk();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
